bldcm_freq_ramp_ctrl: RTL and testbench

Sequencer that drives the motor-speed frequency-to-divider converter's latch handshake so the commanded electrical frequency is reached by bounded steps, not a jump. It accepts a target from the register interface and issues one latch pulse per step. After each pulse it waits for the converter's reflected flag, then dwells a programmable time before the next step. It sits between the control/status registers and the frequency-to-divider block, and owns that block's latch input and frequency bus.

---
 rtl/bldcm_freq_ramp_ctrl_pkg.sv | 32 +++
 rtl/bldcm_freq_step_calc.sv | 13 +
 rtl/bldcm_freq_ramp_ctrl.sv | 135 +++++++++++++
 tb/tb_bldcm_freq_ramp_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bldcm_freq_ramp_ctrl_pkg.sv
// Shared types and step arithmetic for the frequency ramp sequencer.
// The step function is the single definition of the saturating move-toward.
package bldcm_freq_ramp_ctrl_pkg;

  localparam int unsigned FreqWidth = 32;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StLatch    = 2'd1,
    StWaitRefl = 2'd2,
    StDwell    = 2'd3
  } state_e;

  // Move cur toward tgt by at most step; step == 0 jumps straight to tgt.
  function automatic logic [FreqWidth-1:0] next_step(input logic [FreqWidth-1:0] cur,
                                                     input logic [FreqWidth-1:0] tgt,
                                                     input logic [FreqWidth-1:0] step);
    logic [FreqWidth-1:0] diff;
    logic [FreqWidth-1:0] res;
    if (step == '0) begin
      res = tgt;
    end else if (tgt >= cur) begin
      diff = tgt - cur;
      res  = (diff <= step) ? tgt : cur + step;
    end else begin
      diff = cur - tgt;
      res  = (diff <= step) ? tgt : cur - step;
    end
    return res;
  endfunction

endpackage

// File: rtl/bldcm_freq_step_calc.sv
// Combinational next-step calculator: cur/tgt/step -> next frequency.
module bldcm_freq_step_calc
  import bldcm_freq_ramp_ctrl_pkg::*;
(
  input  logic [FreqWidth-1:0] cur_i,
  input  logic [FreqWidth-1:0] tgt_i,
  input  logic [FreqWidth-1:0] step_i,
  output logic [FreqWidth-1:0] next_o
);

  assign next_o = next_step(cur_i, tgt_i, step_i);

endmodule

// File: rtl/bldcm_freq_ramp_ctrl.sv
// Ramp sequencer driving the frequency-to-divider latch handshake in bounded steps,
// with reflect-timeout fault and emergency-stop override.
module bldcm_freq_ramp_ctrl
  import bldcm_freq_ramp_ctrl_pkg::*;
#(
  parameter int unsigned pDwellWidth     = 16,
  parameter logic [31:0] pReflectTimeout = 32'd64
) (
  input  logic                   iClock,
  input  logic                   iReset,
  input  logic [31:0]            iCmdFreq,
  input  logic                   iCmdValid,
  input  logic [31:0]            iStepSize,
  input  logic [pDwellWidth-1:0] iDwellCycles,
  input  logic                   iEmergencyStop,
  input  logic                   iClearFault,
  input  logic                   iFreqReflected,
  output logic                   oLatchFreqTarget,
  output logic [31:0]            oFreqTarget,
  output logic [31:0]            oCurFreq,
  output logic                   oBusy,
  output logic                   oAtTarget,
  output logic                   oFault
);

  state_e                 state_q, state_d;
  logic [31:0]            cmd_q;
  logic [31:0]            cur_q, cur_d;
  logic [31:0]            tgt_q, tgt_d;
  logic                   latch_q, latch_d;
  logic                   fault_q, fault_d;
  logic [31:0]            tmo_q, tmo_d;
  logic [pDwellWidth-1:0] dwell_q, dwell_d;
  logic                   timeout;

  logic [31:0] eff_tgt;
  logic [31:0] eff_step;
  logic [31:0] next_freq;

  assign eff_tgt  = iEmergencyStop ? 32'd0 : cmd_q;
  assign eff_step = iEmergencyStop ? 32'd0 : iStepSize;

  bldcm_freq_step_calc u_step_calc (
    .cur_i  (cur_q),
    .tgt_i  (eff_tgt),
    .step_i (eff_step),
    .next_o (next_freq)
  );

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    latch_d = 1'b0;
    tmo_d   = tmo_q;
    dwell_d = dwell_q;
    timeout = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A latched fault freezes the ramp; only an emergency stop may still move it.
        if ((eff_tgt != cur_q) && (!fault_q || iEmergencyStop)) begin
          tgt_d   = next_freq;
          latch_d = 1'b1;
          state_d = StLatch;
        end
      end
      StLatch: begin
        cur_d   = tgt_q;
        tmo_d   = '0;
        state_d = StWaitRefl;
      end
      StWaitRefl: begin
        if (iFreqReflected) begin
          dwell_d = iDwellCycles;
          state_d = iEmergencyStop ? StIdle : StDwell;
        end else if (tmo_q == pReflectTimeout - 32'd1) begin
          timeout = 1'b1;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      StDwell: begin
        if (iEmergencyStop || (dwell_q == '0)) begin
          state_d = StIdle;
        end else begin
          dwell_d = dwell_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    fault_d = fault_q;
    if (iClearFault) begin
      fault_d = 1'b0;
    end else if (timeout) begin
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state_q <= StIdle;
      cmd_q   <= '0;
      cur_q   <= '0;
      tgt_q   <= '0;
      latch_q <= 1'b0;
      fault_q <= 1'b0;
      tmo_q   <= '0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      if (iCmdValid) begin
        cmd_q <= iCmdFreq;
      end
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      latch_q <= latch_d;
      fault_q <= fault_d;
      tmo_q   <= tmo_d;
      dwell_q <= dwell_d;
    end
  end

  // Latch pulse comes straight from a flop so it cannot glitch on state decode.
  assign oLatchFreqTarget = latch_q;
  assign oFreqTarget      = tgt_q;
  assign oCurFreq         = cur_q;
  assign oBusy            = (state_q != StIdle);
  assign oAtTarget        = (state_q == StIdle) && (cur_q == cmd_q);
  assign oFault           = fault_q;

endmodule

// File: tb/tb_bldcm_freq_ramp_ctrl.sv
// Scoreboard bench for bldcm_freq_ramp_ctrl: expected latch values are queued by the
// stimulus and popped by a monitor on every latch pulse.
module tb_bldcm_freq_ramp_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] cmd_freq;
  logic        cmd_valid;
  logic [31:0] step_size;
  logic [15:0] dwell;
  logic        estop;
  logic        clr_fault;
  logic        refl;
  logic        latch;
  logic [31:0] freq_tgt;
  logic [31:0] cur_freq;
  logic        busy;
  logic        at_tgt;
  logic        fault;

  int          vectors;
  int          miscompares;
  int          latch_cnt;
  logic [31:0] lmin, lmax;
  logic [31:0] exp_q[$];
  logic        conv_en;
  logic [3:0]  rcnt;

  bldcm_freq_ramp_ctrl #(
    .pDwellWidth     (16),
    .pReflectTimeout (32'd64)
  ) dut (
    .iClock           (clk),
    .iReset           (rst),
    .iCmdFreq         (cmd_freq),
    .iCmdValid        (cmd_valid),
    .iStepSize        (step_size),
    .iDwellCycles     (dwell),
    .iEmergencyStop   (estop),
    .iClearFault      (clr_fault),
    .iFreqReflected   (refl),
    .oLatchFreqTarget (latch),
    .oFreqTarget      (freq_tgt),
    .oCurFreq         (cur_freq),
    .oBusy            (busy),
    .oAtTarget        (at_tgt),
    .oFault           (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Converter model: reflected pulses 7 cycles after each latch pulse.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      refl <= 1'b0;
      rcnt <= '0;
    end else begin
      refl <= 1'b0;
      if (latch && conv_en) begin
        rcnt <= 4'd6;
      end else if (rcnt != 0) begin
        rcnt <= rcnt - 4'd1;
        if (rcnt == 4'd1) refl <= 1'b1;
      end
    end
  end

  // Monitor: every latch pulse must match the head of the expected queue.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst && latch) begin
        latch_cnt++;
        if (freq_tgt < lmin) lmin = freq_tgt;
        if (freq_tgt > lmax) lmax = freq_tgt;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_latch: got %0d, expected no latch", freq_tgt);
        end else begin
          e = exp_q.pop_front();
          if (freq_tgt !== e) begin
            miscompares++;
            $display("FAIL latch_value: got %0d, expected %0d", freq_tgt, e);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic send_cmd(input logic [31:0] f);
    @(negedge clk);
    cmd_freq  = f;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_settle(input string name, input logic [31:0] f, input int budget);
    int n = 0;
    while (!(!busy && cur_freq == f && exp_q.size() == 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n >= budget) begin
      miscompares++;
      $display("FAIL %s_timeout: cur=%0d busy=%0d pending=%0d, expected idle at %0d",
               name, cur_freq, busy, exp_q.size(), f);
    end
  endtask

  task automatic wait_latch_val(input string name, input logic [31:0] f, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(latch && freq_tgt == f) && n < budget);
    vectors++;
    if (n >= budget) begin
      miscompares++;
      $display("FAIL %s_timeout: no latch of %0d within %0d cycles", name, f, budget);
    end
  endtask

  task automatic wait_refl(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!refl && n < budget);
    vectors++;
    if (n >= budget) begin
      miscompares++;
      $display("FAIL %s_timeout: no reflected within %0d cycles", name, budget);
    end
  endtask

  initial begin
    int base;
    int n;
    vectors     = 0;
    miscompares = 0;
    latch_cnt   = 0;
    conv_en     = 1'b1;
    rst         = 1'b1;
    cmd_freq    = '0;
    cmd_valid   = 1'b0;
    step_size   = 32'd300;
    dwell       = 16'd4;
    estop       = 1'b0;
    clr_fault   = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_latch", {31'd0, latch}, 0);
    chk("rst_ftgt", freq_tgt, 0);
    chk("rst_cur", cur_freq, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_at", {31'd0, at_tgt}, 1);
    chk("rst_fault", {31'd0, fault}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Ramp up 0 -> 1000 in 300 steps.
    base = latch_cnt;
    exp_q.push_back(300); exp_q.push_back(600);
    exp_q.push_back(900); exp_q.push_back(1000);
    send_cmd(1000);
    wait_settle("ramp", 1000, 200);
    chk("ramp_at", {31'd0, at_tgt}, 1);
    chk("ramp_pulses", latch_cnt - base, 4);

    // Direct drop to 0.
    step_size = 0;
    exp_q.push_back(0);
    send_cmd(0);
    wait_settle("drop", 0, 50);

    // Reversal during DWELL after 600.
    step_size = 300;
    lmin = 32'hFFFF_FFFF; lmax = 0;
    exp_q.push_back(300); exp_q.push_back(600);
    send_cmd(900);
    wait_latch_val("rev600", 600, 100);
    wait_refl("rev_refl", 20);
    exp_q.push_back(300); exp_q.push_back(100);
    send_cmd(100);
    wait_settle("rev", 100, 200);
    chk("rev_range", {31'd0, (lmin >= 100 && lmax <= 900)}, 1);

    // Emergency stop at 900.
    step_size = 400;
    exp_q.push_back(500); exp_q.push_back(900);
    send_cmd(2000);
    wait_latch_val("es900", 900, 100);
    estop = 1'b1;
    exp_q.push_back(0);
    wait_refl("es_refl", 20);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!latch && n < 20);
    chk("es_gap", n, 2);
    wait_settle("es", 0, 50);
    chk("es_at", {31'd0, at_tgt}, 0);
    chk("es_cur", cur_freq, 0);
    send_cmd(0);
    estop = 1'b0;
    @(negedge clk);
    chk("es_release_at", {31'd0, at_tgt}, 1);

    // Reflect timeout.
    step_size = 300;
    conv_en   = 1'b0;
    exp_q.push_back(300);
    send_cmd(300);
    wait_latch_val("tmo300", 300, 20);
    repeat (64) @(negedge clk);
    chk("tmo_fault_early", {31'd0, fault}, 0);
    @(negedge clk);
    chk("tmo_fault", {31'd0, fault}, 1);
    chk("tmo_busy", {31'd0, busy}, 0);
    send_cmd(600);
    repeat (20) @(negedge clk);
    chk("tmo_hold_fault", {31'd0, fault}, 1);
    chk("tmo_hold_cur", cur_freq, 300);
    conv_en = 1'b1;
    exp_q.push_back(600);
    @(negedge clk);
    clr_fault = 1'b1;
    @(negedge clk);
    clr_fault = 1'b0;
    wait_settle("clr", 600, 100);
    chk("clr_fault", {31'd0, fault}, 0);

    // Direct jump.
    step_size = 0;
    base = latch_cnt;
    exp_q.push_back(5000);
    send_cmd(5000);
    wait_settle("jump", 5000, 50);
    chk("jump_pulses", latch_cnt - base, 1);

    // Asynchronous reset while in WAIT_REFL.
    step_size = 300;
    exp_q.push_back(5300);
    send_cmd(5600);
    wait_latch_val("mr5300", 5300, 20);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mr_latch", {31'd0, latch}, 0);
    chk("mr_ftgt", freq_tgt, 0);
    chk("mr_cur", cur_freq, 0);
    chk("mr_busy", {31'd0, busy}, 0);
    chk("mr_at", {31'd0, at_tgt}, 1);
    chk("mr_fault", {31'd0, fault}, 0);
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mr_hold_latch", {31'd0, latch}, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mr_post_at", {31'd0, at_tgt}, 1);
    chk("mr_post_busy", {31'd0, busy}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
